// File: rtl/clock_tick_monitor_if.sv
// Signal bundle between the slow-clock monitor (master) and the logic that
// consumes its ticks and lock status (slave).
interface clock_tick_monitor_if #(
    parameter int CW = 32
);
    logic          slow_clk;
    logic          rise_tick;
    logic          fall_tick;
    logic [CW-1:0] half_count;
    logic          count_valid;
    logic          locked;
    logic          err;
    logic          timeout;

    modport master (
        input  slow_clk,
        output rise_tick, fall_tick, half_count, count_valid, locked, err, timeout
    );

    modport slave (
        output slow_clk,
        input  rise_tick, fall_tick, half_count, count_valid, locked, err, timeout
    );
endinterface

// File: rtl/clock_tick_monitor.sv
// Samples a divided slow clock in the fast domain, emits rise/fall enable
// ticks, measures every half-period and tracks whether the slow clock is locked.
module clock_tick_monitor #(
    parameter int HALF_PERIOD = 50000,
    parameter int TOL         = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int CW          = 32
) (
    input  logic                 in_clk,
    input  logic                 reset,
    clock_tick_monitor_if.master mon
);
    localparam int GW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [CW-1:0] LO_BOUND = CW'(HALF_PERIOD - TOL);
    localparam logic [CW-1:0] HI_BOUND = CW'(HALF_PERIOD + TOL);
    localparam logic [CW-1:0] TO_LIMIT = CW'(2 * HALF_PERIOD);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Synchronizer and edge history are free-running so the edge detector
    // already holds the settled level when reset is released.
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge in_clk) begin
        sync1_q <= mon.slow_clk;
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
    end

    logic rise, fall, edge_evt, in_range;

    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign edge_evt = rise | fall;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [CW-1:0] half_count_q, half_count_d;
    logic          rise_tick_q, rise_tick_d;
    logic          fall_tick_q, fall_tick_d;
    logic          count_valid_q, count_valid_d;
    logic          err_q, err_d;
    logic          timeout_q, timeout_d;
    logic          locked_q, locked_d;

    // cnt_q holds the cycles since the last edge, so it is the measurement.
    assign in_range = (cnt_q >= LO_BOUND) && (cnt_q <= HI_BOUND);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        good_d        = good_q;
        half_count_d  = half_count_q;
        rise_tick_d   = rise;
        fall_tick_d   = fall;
        count_valid_d = 1'b0;
        err_d         = 1'b0;
        timeout_d     = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (edge_evt) begin
                    cnt_d   = CW'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (edge_evt) begin
                    cnt_d         = CW'(1);
                    half_count_d  = cnt_q;
                    count_valid_d = 1'b1;
                    if (!in_range) begin
                        good_d  = '0;
                        err_d   = 1'b1;
                        state_d = MEASURE;
                    end else if (state_q == MEASURE) begin
                        good_d = good_q + 1'b1;
                        if (good_d >= GOOD_MAX) state_d = LOCKED;
                    end
                end else if (cnt_q >= TO_LIMIT) begin
                    // An edge in the same cycle takes the branch above instead.
                    timeout_d = 1'b1;
                    good_d    = '0;
                    cnt_d     = '0;
                    state_d   = SEARCH;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q       <= SEARCH;
            cnt_q         <= '0;
            good_q        <= '0;
            half_count_q  <= '0;
            rise_tick_q   <= 1'b0;
            fall_tick_q   <= 1'b0;
            count_valid_q <= 1'b0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            good_q        <= good_d;
            half_count_q  <= half_count_d;
            rise_tick_q   <= rise_tick_d;
            fall_tick_q   <= fall_tick_d;
            count_valid_q <= count_valid_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            locked_q      <= locked_d;
        end
    end

    assign mon.rise_tick   = rise_tick_q;
    assign mon.fall_tick   = fall_tick_q;
    assign mon.half_count  = half_count_q;
    assign mon.count_valid = count_valid_q;
    assign mon.err         = err_q;
    assign mon.timeout     = timeout_q;
    assign mon.locked      = locked_q;
endmodule

// File: doc/clock_tick_monitor.md
# clock_tick_monitor

Receiving end of the project's divided-clock scheme. It samples a slow square-wave clock (nominally produced by dividing the 100 MHz board clock) inside the 100 MHz domain. It emits single-cycle rise/fall enable ticks, measures each half-period in in_clk cycles, and reports whether the slow clock is present and within tolerance (locked). Game logic uses the ticks as clock enables instead of clocking flops from the divided clock directly.

## Interface
Parameters:
- HALF_PERIOD, 50000: expected half-period of slow_clk in in_clk cycles.
- TOL, 16: allowed deviation, inclusive, from HALF_PERIOD.
- LOCK_COUNT, 4: consecutive in-range half-periods required to assert locked.
- CW, 32: width of the period counter and half_count.

Ports:
- in_clk  in  1  100 MHz system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- slow_clk  in  1  monitored slow clock; asynchronous to in_clk.
- rise_tick  out  1  one-cycle pulse per detected rising edge.
- fall_tick  out  1  one-cycle pulse per detected falling edge.
- half_count  out  CW  last measured half-period in cycles; holds between updates.
- count_valid  out  1  one-cycle pulse when half_count is updated.
- locked  out  1  level; slow_clk is in tolerance.
- err  out  1  one-cycle pulse on an out-of-range measurement.
- timeout  out  1  one-cycle pulse when slow_clk stops.

## Operation
- Synchronizer: two flops (sync1, sync2). They are not reset. Edge register prev loads sync2 every cycle, including during reset.
- Edge detect: rise = sync2 & ~prev, fall = ~sync2 & prev. An edge event is either one.
- Period counter cnt:
  - Cleared to 1 on each edge event; otherwise increments.
  - Saturates at 2^CW-1.
  - On an edge, the measured value is the cnt value before clearing, which equals the cycles since the previous edge (50000 for an ideal divider).
- In-range test: HALF_PERIOD-TOL <= m <= HALF_PERIOD+TOL. Bounds are inclusive; the comparison is unsigned at CW bits.
- good: counter, 0..LOCK_COUNT.
- States:
  - SEARCH (reset state): the first edge starts cnt and moves to MEASURE. No measurement, no count_valid.
  - MEASURE: on each edge, update half_count and pulse count_valid.
    - In range: good+1. When good reaches LOCK_COUNT, go to LOCKED.
    - Out of range: good=0 and pulse err.
  - LOCKED: locked=1. In-range edges update half_count and count_valid only. An out-of-range edge pulses err, sets good=0 and moves to MEASURE.
  - Timeout, from MEASURE or LOCKED: if cnt reaches 2*HALF_PERIOD with no edge, pulse timeout, set good=0 and go to SEARCH. The next edge restarts cnt only.
- Simultaneous edge and timeout in the same cycle: the edge wins. The measurement is processed and timeout is not pulsed.
- Ticks are generated in every state, independent of locked.

## Timing
- Reset values: rise_tick, fall_tick, count_valid, err, timeout, locked = 0; half_count = 0; state SEARCH; good = 0; cnt = 0.
- Reset asserted mid-operation clears all of the above on the next posedge, regardless of state.
- Tick latency: if slow_clk changes before posedge k, the tick is high for exactly the one cycle following posedge k+2.
- count_valid, err and half_count update in that same cycle as the tick.
- locked rises in the same cycle as the count_valid of the LOCK_COUNT-th good measurement. It falls in the same cycle as err or timeout.
- Outputs are registered; no combinational path from slow_clk to any output.
- Minimum resolvable half-period: 3 cycles. Shorter pulses may be missed; no further requirement.

## Test plan
1. Hold slow_clk=1 through reset, release, and hold for 1000 cycles: all outputs remain 0 and there are no ticks.
2. Square wave with half-period 50000 starting after reset:
   - rise_tick and fall_tick alternate, each exactly 1 cycle wide.
   - Edge 1 gives no count_valid.
   - Edges 2–5 each give count_valid with half_count=50000.
   - locked goes to 1 with edge 5's count_valid; err and timeout stay 0.
3. While locked, one half-period of 50017: err pulses, locked goes to 0, half_count=50017. Four more half-periods of 50000 bring locked back to 1.
4. Boundary half-periods of 49984 and 50016: no err and locked is kept. Half-period of 49983: err.
5. While locked, stop toggling: timeout pulses exactly 100000 cycles after the last edge's cnt clear, and locked goes to 0. The next edge gives a tick but no count_valid.
6. Assert reset for 1 cycle mid-MEASURE (good=2): locked and good are 0. After release, lock requires 1 start edge plus 4 good measurements again.
